// File: rtl/axi_rd_arbiter.sv
// N-master AXI3 read-channel arbiter: round-robin AR arbitration, ARID = master index, R beats routed by RID.
// Define AXI_RD_ARB_LIMIT_EN to cap outstanding bursts per master at MAX_OUT.
module axi_rd_arbiter #(
    parameter int          N_MASTERS = 2,
    parameter int          MAX_OUT   = 2,
    parameter logic [15:0] WRAP_MASK = 16'b01,
    parameter logic [15:0] INST_MASK = 16'b01
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_MASTERS-1:0]     req,
    input  logic [32*N_MASTERS-1:0]  addr,
    input  logic [4*N_MASTERS-1:0]   len,
    input  logic [3*N_MASTERS-1:0]   size,
    output logic [N_MASTERS-1:0]     addr_ok,
    output logic [31:0]              rdata,
    output logic [N_MASTERS-1:0]     rvalid,
    output logic [N_MASTERS-1:0]     data_ok,
    output logic [3:0]               arid,
    output logic [31:0]              araddr,
    output logic [3:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    output logic [1:0]               arlock,
    output logic [3:0]               arcache,
    output logic [2:0]               arprot,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [3:0]               rid,
    input  logic [31:0]              rdata_axi,
    input  logic [1:0]               rresp,
    input  logic                     rlast,
    input  logic                     rvalid_axi,
    output logic                     rready,
    output logic                     rid_err
);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                 state_q, state_d;
    logic [N_MASTERS-1:0]   eligible;
    logic                   pick_valid;
    logic [3:0]             pick;
    logic [3:0]             ptr_q;
    logic [3:0]             next_ptr;
    logic [3:0]             grant_q;
    logic [31:0]            addr_q;
    logic [3:0]             len_q;
    logic [2:0]             size_q;
    logic [1:0]             burst_q;
    logic [2:0]             prot_q;
    logic                   accept;
    logic                   unused_resp;

    assign unused_resp = &{1'b0, rresp};
    assign accept      = (state_q == ISSUE) && arready;
    assign next_ptr    = (int'(grant_q) + 1 >= N_MASTERS) ? 4'd0 : grant_q + 4'd1;

`ifdef AXI_RD_ARB_LIMIT_EN
    localparam int CW = $clog2(MAX_OUT + 1);

    logic [CW-1:0]          count [N_MASTERS];
    logic [N_MASTERS-1:0]   cnt_inc;
    logic [N_MASTERS-1:0]   cnt_dec;

    always_comb begin
        cnt_inc  = '0;
        cnt_dec  = '0;
        eligible = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            cnt_inc[i]  = accept && (grant_q == 4'(i));
            cnt_dec[i]  = rvalid_axi && rlast && (rid == 4'(i));
            eligible[i] = req[i] && (count[i] < CW'(MAX_OUT));
        end
    end

    // A late last beat after reset can arrive with the count already at zero, so decrement saturates.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_MASTERS; i++) begin
            if (rst) begin
                count[i] <= '0;
            end else if (cnt_inc[i] && !cnt_dec[i]) begin
                count[i] <= count[i] + 1'b1;
            end else if (!cnt_inc[i] && cnt_dec[i] && (count[i] != '0)) begin
                count[i] <= count[i] - 1'b1;
            end
        end
    end
`else
    assign eligible = req;
`endif

    // Walk downward so the last hit is the first eligible index at or after ptr.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        for (int k = N_MASTERS - 1; k >= 0; k--) begin
            if (eligible[(int'(ptr_q) + k) % N_MASTERS]) begin
                pick_valid = 1'b1;
                pick       = 4'((int'(ptr_q) + k) % N_MASTERS);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_valid) state_d = ISSUE;
            ISSUE:   if (arready)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // AR fields come only from these registers so they stay stable while arready is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            grant_q <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= 2'b01;
            prot_q  <= 3'b001;
        end else if ((state_q == IDLE) && pick_valid) begin
            grant_q <= pick;
            addr_q  <= addr[32*int'(pick) +: 32];
            len_q   <= len[4*int'(pick) +: 4];
            size_q  <= size[3*int'(pick) +: 3];
            burst_q <= WRAP_MASK[pick] ? 2'b10 : 2'b01;
            prot_q  <= INST_MASK[pick] ? 3'b101 : 3'b001;
        end else if (accept) begin
            ptr_q   <= next_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rid_err <= 1'b0;
        end else if (rvalid_axi && (int'(rid) >= N_MASTERS)) begin
            rid_err <= 1'b1;
        end
    end

    always_comb begin
        addr_ok = '0;
        rvalid  = '0;
        data_ok = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            addr_ok[i] = accept && (grant_q == 4'(i));
            rvalid[i]  = rvalid_axi && (rid == 4'(i));
            data_ok[i] = rvalid_axi && rlast && (rid == 4'(i));
        end
    end

    assign arvalid = (state_q == ISSUE);
    assign arid    = grant_q;
    assign araddr  = addr_q;
    assign arlen   = len_q;
    assign arsize  = size_q;
    assign arburst = burst_q;
    assign arprot  = prot_q;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign rready  = 1'b1;
    assign rdata   = rdata_axi;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: a 2-master and a 4-master instance sharing the R channel inputs.
// Honours AXI_RD_ARB_LIMIT_EN when the design is built with it.
module tb_axi_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  rid;
    logic [31:0] rdata_axi;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid_axi;

    logic [1:0]  req2, addr_ok2, rvalid2, data_ok2;
    logic [63:0] addr2;
    logic [7:0]  len2;
    logic [5:0]  size2;
    logic [31:0] rdata2, araddr2;
    logic [3:0]  arid2, arlen2, arcache2;
    logic [2:0]  arsize2, arprot2;
    logic [1:0]  arburst2, arlock2;
    logic        arvalid2, arready2, rready2, rid_err2;

    logic [3:0]   req4, addr_ok4, rvalid4, data_ok4;
    logic [127:0] addr4;
    logic [15:0]  len4;
    logic [11:0]  size4;
    logic [31:0]  rdata4, araddr4;
    logic [3:0]   arid4, arlen4, arcache4;
    logic [2:0]   arsize4, arprot4;
    logic [1:0]   arburst4, arlock4;
    logic         arvalid4, arready4, rready4, rid_err4;

    int check_count = 0;
    int pass_count  = 0;

    always #5 clk = ~clk;

    axi_rd_arbiter #(.N_MASTERS(2), .MAX_OUT(2), .WRAP_MASK(16'h1), .INST_MASK(16'h1)) dut (
        .clk(clk), .rst(rst), .req(req2), .addr(addr2), .len(len2), .size(size2),
        .addr_ok(addr_ok2), .rdata(rdata2), .rvalid(rvalid2), .data_ok(data_ok2),
        .arid(arid2), .araddr(araddr2), .arlen(arlen2), .arsize(arsize2), .arburst(arburst2),
        .arlock(arlock2), .arcache(arcache2), .arprot(arprot2), .arvalid(arvalid2), .arready(arready2),
        .rid(rid), .rdata_axi(rdata_axi), .rresp(rresp), .rlast(rlast), .rvalid_axi(rvalid_axi),
        .rready(rready2), .rid_err(rid_err2)
    );

    axi_rd_arbiter #(.N_MASTERS(4), .MAX_OUT(2), .WRAP_MASK(16'h1), .INST_MASK(16'h1)) dut4 (
        .clk(clk), .rst(rst), .req(req4), .addr(addr4), .len(len4), .size(size4),
        .addr_ok(addr_ok4), .rdata(rdata4), .rvalid(rvalid4), .data_ok(data_ok4),
        .arid(arid4), .araddr(araddr4), .arlen(arlen4), .arsize(arsize4), .arburst(arburst4),
        .arlock(arlock4), .arcache(arcache4), .arprot(arprot4), .arvalid(arvalid4), .arready(arready4),
        .rid(rid), .rdata_axi(rdata_axi), .rresp(rresp), .rlast(rlast), .rvalid_axi(rvalid_axi),
        .rready(rready4), .rid_err(rid_err4)
    );

    // Advance n cycles; inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic applyStimulus(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        if (obs === exp) pass_count++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(2);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rid = '0; rdata_axi = '0; rresp = 2'b10; rlast = 1'b0; rvalid_axi = 1'b0;
        req2 = '0; arready2 = 1'b1;
        addr2 = {32'h2000_0040, 32'h1000_0080}; len2 = {4'd3, 4'd7}; size2 = {3'd1, 3'd2};
        req4 = '0; arready4 = 1'b1;
        addr4 = {32'h4000_0300, 32'h4000_0200, 32'h4000_0100, 32'h4000_0000};
        len4 = '0; size4 = '0;

        // Reset state
        applyStimulus(2);
        checkOutput("rst_arvalid", arvalid2, 0);
        checkOutput("rst_addr_ok", addr_ok2, 0);
        checkOutput("rst_rid_err", rid_err2, 0);
        checkOutput("rst_arvalid4", arvalid4, 0);
        rst = 1'b0;

        // Two masters from reset: master 0 first (wrap, inst), then master 1
        req2 = 2'b11;
        applyStimulus(1);
        checkOutput("g0_arvalid", arvalid2, 1);
        checkOutput("g0_arid", arid2, 0);
        checkOutput("g0_araddr", araddr2, 32'h1000_0080);
        checkOutput("g0_arlen", arlen2, 7);
        checkOutput("g0_arsize", arsize2, 2);
        checkOutput("g0_arburst", arburst2, 2'b10);
        checkOutput("g0_arprot", arprot2, 3'b101);
        checkOutput("g0_addr_ok", addr_ok2, 2'b01);
        checkOutput("consts", {arlock2, arcache2, rready2}, 7'b0000001);
        req2 = 2'b10;
        applyStimulus(1);
        checkOutput("gap_arvalid", arvalid2, 0);
        checkOutput("gap_addr_ok", addr_ok2, 0);
        applyStimulus(1);
        checkOutput("g1_arid", arid2, 1);
        checkOutput("g1_araddr", araddr2, 32'h2000_0040);
        checkOutput("g1_arlen", arlen2, 3);
        checkOutput("g1_arburst", arburst2, 2'b01);
        checkOutput("g1_arprot", arprot2, 3'b001);
        checkOutput("g1_addr_ok", addr_ok2, 2'b10);
        req2 = 2'b00;
        applyStimulus(1);

        // Four masters, 0/2/3 held: order 0,2,3,0 with a 5-cycle AR stall on master 2
        doReset();
        req4 = 4'b1101;
        applyStimulus(1);
        checkOutput("n4_g0_arid", arid4, 0);
        checkOutput("n4_g0_ok", addr_ok4, 4'b0001);
        applyStimulus(1);
        checkOutput("n4_idle", arvalid4, 0);
        arready4 = 1'b0;
        applyStimulus(1);
        checkOutput("n4_g2_arid", arid4, 2);
        checkOutput("n4_g2_addr", araddr4, 32'h4000_0200);
        checkOutput("n4_g2_ok_low", addr_ok4, 0);
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1);
            checkOutput("n4_stall_valid", arvalid4, 1);
            checkOutput("n4_stall_addr", araddr4, 32'h4000_0200);
            checkOutput("n4_stall_ok", addr_ok4, 0);
        end
        arready4 = 1'b1;
        #1;
        checkOutput("n4_g2_ok", addr_ok4, 4'b0100);
        applyStimulus(2);
        checkOutput("n4_g3_arid", arid4, 3);
        checkOutput("n4_g3_addr", araddr4, 32'h4000_0300);
        applyStimulus(2);
        checkOutput("n4_g0b_arid", arid4, 0);
        checkOutput("n4_g0b_ok", addr_ok4, 4'b0001);
        req4 = '0;
        applyStimulus(1);

        // R routing: 4-beat burst on rid 1
        for (int b = 0; b < 4; b++) begin
            rid = 4'd1; rvalid_axi = 1'b1; rlast = (b == 3); rdata_axi = 32'hCAFE_00A0 + b;
            #1;
            checkOutput("r_rvalid", rvalid2, 2'b10);
            checkOutput("r_data_ok", data_ok2, (b == 3) ? 32'h2 : 32'h0);
            checkOutput("r_rdata", rdata2, 32'hCAFE_00A0 + b);
            checkOutput("r_rvalid4", rvalid4, 4'b0010);
            applyStimulus(1);
        end
        rvalid_axi = 1'b0; rlast = 1'b1;
        #1;
        checkOutput("r_nolast_ok", data_ok2, 0);
        checkOutput("r_nolast_valid", rvalid2, 0);
        rlast = 1'b0;

        // Out-of-range RID: dropped and sticky error
        rid = 4'd5; rvalid_axi = 1'b1; rlast = 1'b1;
        #1;
        checkOutput("bad_rvalid", rvalid2, 0);
        checkOutput("bad_data_ok", data_ok2, 0);
        applyStimulus(1);
        rvalid_axi = 1'b0; rlast = 1'b0; rid = 4'd0;
        checkOutput("bad_err", rid_err2, 1);
        checkOutput("bad_err4", rid_err4, 1);
        applyStimulus(3);
        checkOutput("bad_err_sticky", rid_err2, 1);
        doReset();
        checkOutput("bad_err_clr", rid_err2, 0);

        // Outstanding limit: master 0 granted twice, then held off until a burst completes
        req2 = 2'b01;
        applyStimulus(1);
        checkOutput("lim_g1", arid2, 0);
        applyStimulus(2);
        checkOutput("lim_g2_valid", arvalid2, 1);
        checkOutput("lim_g2", arid2, 0);
        applyStimulus(1);
        req2 = 2'b11;
        applyStimulus(1);
        checkOutput("lim_m1_valid", arvalid2, 1);
        checkOutput("lim_m1", arid2, 1);
        req2 = 2'b01;
        applyStimulus(2);
`ifdef AXI_RD_ARB_LIMIT_EN
        checkOutput("lim_block", arvalid2, 0);
        applyStimulus(1);
        checkOutput("lim_block2", arvalid2, 0);
        rid = 4'd0; rvalid_axi = 1'b1; rlast = 1'b1;
        applyStimulus(1);
        rvalid_axi = 1'b0; rlast = 1'b0;
        checkOutput("lim_wait", arvalid2, 0);
        applyStimulus(1);
        checkOutput("lim_resume_valid", arvalid2, 1);
        checkOutput("lim_resume", arid2, 0);
`else
        checkOutput("nolim_g3_valid", arvalid2, 1);
        checkOutput("nolim_g3", arid2, 0);
`endif
        req2 = 2'b00;
        applyStimulus(2);

        // Reset during a stalled ISSUE: pointer and counts cleared
        doReset();
        req2 = 2'b01;
        applyStimulus(1);
        req2 = 2'b00;
        applyStimulus(1);
        arready2 = 1'b0; req2 = 2'b11;
        applyStimulus(1);
        checkOutput("stall_g1", arid2, 1);
        checkOutput("stall_valid", arvalid2, 1);
        rst = 1'b1;
        applyStimulus(1);
        checkOutput("mid_rst_arvalid", arvalid2, 0);
        checkOutput("mid_rst_addr_ok", addr_ok2, 0);
        rst = 1'b0; req2 = 2'b00; arready2 = 1'b1;
        rid = 4'd0; rvalid_axi = 1'b1; rlast = 1'b1;
        #1;
        checkOutput("late_beat_route", rvalid2, 2'b01);
        applyStimulus(1);
        rvalid_axi = 1'b0; rlast = 1'b0;
        req2 = 2'b11;
        applyStimulus(1);
        checkOutput("post_rst_valid", arvalid2, 1);
        checkOutput("post_rst_arid", arid2, 0);
        checkOutput("post_rst_ok", addr_ok2, 2'b01);
        req2 = 2'b00;
        applyStimulus(2);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
